// File: rtl/game_sequencer.sv
// game_sequencer: brick-breaker game-flow FSM (menu, level load, serve, play, win, lose)
// Ports:
//   clk, rst                       system clock, synchronous active-high reset
//   tick                           one-cycle game-step strobe
//   start_press, pause_press       one-cycle button pulses (pause only acts with PAUSE_EN)
//   ball_lost, bricks_clear        level inputs from the ball/brick datapath
//   load_done                      one-cycle completion pulse from the brick loader
//   state, level, lives            registered game status
//   load_req, ball_reset, run      registered commands to the brick loader and ball controller
// Build option: define PAUSE_EN to enable the PAUSE state (state 6).
module game_sequencer #(
    parameter int NUM_LEVELS  = 3,
    parameter int START_LIVES = 3,
    parameter int SERVE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_press,
    input  logic       pause_press,
    input  logic       ball_lost,
    input  logic       bricks_clear,
    input  logic       load_done,
    output logic [2:0] state,
    output logic [1:0] level,
    output logic [2:0] lives,
    output logic       load_req,
    output logic       ball_reset,
    output logic       run
);
    localparam int CW = SERVE_TICKS > 0 ? $clog2(SERVE_TICKS + 1) : 1;
    localparam logic [2:0] S_MENU  = 3'd0;
    localparam logic [2:0] S_WIN   = 3'd1;
    localparam logic [2:0] S_LOSE  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_SERVE = 3'd4;
    localparam logic [2:0] S_LOAD  = 3'd5;
`ifdef PAUSE_EN
    localparam logic [2:0] S_PAUSE = 3'd6;
`endif
    localparam logic [1:0]    LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [2:0]    LIVES0     = 3'(START_LIVES);
    localparam logic [CW-1:0] CNT0       = CW'(SERVE_TICKS);

    logic [2:0]    state_n, lives_n;
    logic [1:0]    level_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          load_req_n, ball_reset_n, pause_go;

`ifdef PAUSE_EN
    assign pause_go = pause_press;
`else
    logic unused_pause;
    assign unused_pause = pause_press;
    assign pause_go     = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        level_n      = level;
        lives_n      = lives;
        cnt_n        = cnt;
        load_req_n   = 1'b0;
        ball_reset_n = 1'b0;
        case (state)
            S_MENU: if (start_press) begin
                state_n    = S_LOAD;
                level_n    = '0;
                lives_n    = LIVES0;
                load_req_n = 1'b1;
            end
            S_LOAD: if (load_done) begin
                state_n      = S_SERVE;
                ball_reset_n = 1'b1;
                cnt_n        = CNT0;
            end
            S_SERVE: if (tick) begin
                state_n = cnt == '0 ? S_PLAY : S_SERVE;
                cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
            end
            S_PLAY: begin
                // pause takes precedence over a coincident tick
                if (pause_go) begin
`ifdef PAUSE_EN
                    state_n = S_PAUSE;
`endif
                end else if (tick && bricks_clear) begin
                    state_n    = level == LAST_LEVEL ? S_WIN : S_LOAD;
                    level_n    = level == LAST_LEVEL ? level : level + 1'b1;
                    load_req_n = level != LAST_LEVEL;
                end else if (tick && ball_lost) begin
                    state_n      = lives <= 3'd1 ? S_LOSE : S_SERVE;
                    lives_n      = lives <= 3'd1 ? 3'd0 : lives - 1'b1;
                    ball_reset_n = lives > 3'd1;
                    cnt_n        = lives > 3'd1 ? CNT0 : cnt;
                end
            end
`ifdef PAUSE_EN
            S_PAUSE: if (pause_press) state_n = S_PLAY;
`endif
            S_WIN, S_LOSE: if (start_press) state_n = S_MENU;
            default: state_n = S_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_MENU;
            level      <= '0;
            lives      <= LIVES0;
            cnt        <= '0;
            load_req   <= 1'b0;
            ball_reset <= 1'b0;
            run        <= 1'b0;
        end else begin
            state      <= state_n;
            level      <= level_n;
            lives      <= lives_n;
            cnt        <= cnt_n;
            load_req   <= load_req_n;
            ball_reset <= ball_reset_n;
            run        <= state_n == S_PLAY;
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed table-driven bench for game_sequencer
module tb_game_sequencer;
    logic       clk = 1'b0;
    logic       rst, tick, start_press, pause_press, ball_lost, bricks_clear, load_done;
    logic [2:0] state, lives;
    logic [1:0] level;
    logic       load_req, ball_reset, run;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start_press(start_press),
        .pause_press(pause_press), .ball_lost(ball_lost), .bricks_clear(bricks_clear),
        .load_done(load_done), .state(state), .level(level), .lives(lives),
        .load_req(load_req), .ball_reset(ball_reset), .run(run)
    );

`ifdef PAUSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    localparam logic [6:0] R  = 7'b1000000;
    localparam logic [6:0] T  = 7'b0100000;
    localparam logic [6:0] S  = 7'b0010000;
    localparam logic [6:0] P  = 7'b0001000;
    localparam logic [6:0] BL = 7'b0000100;
    localparam logic [6:0] BC = 7'b0000010;
    localparam logic [6:0] LD = 7'b0000001;
    localparam logic [6:0] NO = 7'b0000000;

    typedef struct {
        string      name;
        int         n;
        logic [6:0] in;
        logic [2:0] st;
        logic [1:0] lv;
        logic [2:0] li;
        logic [2:0] pl;
    } vec_t;

    vec_t q[$];

    task automatic add(input string nm, input int n, input logic [6:0] in,
                       input logic [2:0] st, input logic [1:0] lv, input logic [2:0] li,
                       input logic [2:0] pl);
        q.push_back('{nm, n, in, st, lv, li, pl});
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        {rst, tick, start_press, pause_press, ball_lost, bricks_clear, load_done} = v.in;
        repeat (v.n) @(posedge clk);
        #1;
        checks++;
        if ({state, level, lives, load_req, ball_reset, run} !== {v.st, v.lv, v.li, v.pl}) begin
            errors++;
            $display("FAIL %s: got state=%0d level=%0d lives=%0d lr/br/run=%b%b%b, expected state=%0d level=%0d lives=%0d lr/br/run=%b",
                     v.name, state, level, lives, load_req, ball_reset, run, v.st, v.lv, v.li, v.pl);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        {rst, tick, start_press, pause_press, ball_lost, bricks_clear, load_done} = '0;
        add("reset",           1, R,          0, 0, 3, 3'b000);
        add("idle_menu",       1, NO,         0, 0, 3, 3'b000);
        add("start_and_tick",  1, T | S,      5, 0, 3, 3'b100);
        add("load_req_drop",   1, NO,         5, 0, 3, 3'b000);
        add("start_in_load",   1, S,          5, 0, 3, 3'b000);
        add("load_done",       1, LD,         4, 0, 3, 3'b010);
        add("ball_reset_drop", 1, NO,         4, 0, 3, 3'b000);
        add("serve_20_ticks",  20, T,         4, 0, 3, 3'b000);
        add("serve_last_tick", 1, T | BL | BC, 3, 0, 3, 3'b001);
        add("no_tick_in_play", 1, BL,         3, 0, 3, 3'b001);
        add("lost_1",          1, T | BL,     4, 0, 2, 3'b010);
        add("serve_2",         21, T,         3, 0, 2, 3'b001);
        add("lost_2",          1, T | BL,     4, 0, 1, 3'b010);
        add("serve_3",         21, T,         3, 0, 1, 3'b001);
        add("pause_1",         1, P,          PE ? 3'd6 : 3'd3, 0, 1, PE ? 3'b000 : 3'b001);
        add("lost_3",          1, T | BL,     PE ? 3'd6 : 3'd2, 0, PE ? 3'd1 : 3'd0, 3'b000);
        add("pause_2",         1, P,          PE ? 3'd3 : 3'd2, 0, PE ? 3'd1 : 3'd0, PE ? 3'b001 : 3'b000);
        add("lost_final",      1, T | BL,     2, 0, 0, 3'b000);
        add("lose_to_menu",    1, S,          0, 0, 0, 3'b000);
        add("load_done_menu",  1, LD,         0, 0, 0, 3'b000);
        add("restart",         1, S,          5, 0, 3, 3'b100);
        add("load_l0",         1, LD,         4, 0, 3, 3'b010);
        add("serve_l0",        21, T,         3, 0, 3, 3'b001);
        add("clear_l0",        1, T | BC,     5, 1, 3, 3'b100);
        add("ld_with_req",     1, LD,         4, 1, 3, 3'b010);
        add("serve_l1",        21, T,         3, 1, 3, 3'b001);
        add("clear_l1",        1, T | BC,     5, 2, 3, 3'b100);
        add("wait_l2",         1, NO,         5, 2, 3, 3'b000);
        add("load_l2",         1, LD,         4, 2, 3, 3'b010);
        add("serve_l2",        21, T,         3, 2, 3, 3'b001);
        add("clear_last",      1, T | BC | BL, 1, 2, 3, 3'b000);
        add("tick_in_win",     1, T,          1, 2, 3, 3'b000);
        add("win_to_menu",     1, S,          0, 2, 3, 3'b000);
        add("prio_start",      1, S,          5, 0, 3, 3'b100);
        add("prio_load",       1, LD,         4, 0, 3, 3'b010);
        add("prio_serve1",     21, T,         3, 0, 3, 3'b001);
        add("prio_lost1",      1, T | BL,     4, 0, 2, 3'b010);
        add("prio_serve2",     21, T,         3, 0, 2, 3'b001);
        add("prio_lost2",      1, T | BL,     4, 0, 1, 3'b010);
        add("prio_serve3",     21, T,         3, 0, 1, 3'b001);
        add("clear_beats_lost", 1, T | BC | BL, 5, 1, 1, 3'b100);
        add("rst_mid_load",    1, R,          0, 0, 3, 3'b000);
        add("rs_start",        1, S,          5, 0, 3, 3'b100);
        add("rs_load",         1, LD,         4, 0, 3, 3'b010);
        add("rs_partial",      5, T,          4, 0, 3, 3'b000);
        add("rst_mid_serve",   1, R,          0, 0, 3, 3'b000);
        add("re_start",        1, S,          5, 0, 3, 3'b100);
        add("re_load",         1, LD,         4, 0, 3, 3'b010);
        add("re_serve_20",     20, T,         4, 0, 3, 3'b000);
        add("re_serve_21",     1, T,          3, 0, 3, 3'b001);
        add("rst_in_play",     1, R,          0, 0, 3, 3'b000);
        add("hs_start",        1, S,          5, 0, 3, 3'b100);
        add("hs_load",         1, LD,         4, 0, 3, 3'b010);
        foreach (q[i]) apply(q[i]);

        begin
            int k;
            k = 0;
            @(negedge clk);
            {rst, tick, start_press, pause_press, ball_lost, bricks_clear, load_done} = T;
            while (!run && k < 40) begin
                @(posedge clk);
                #1;
                k++;
            end
            tick = 1'b0;
            checks++;
            if (k != 21) begin
                errors++;
                $display("FAIL serve_tick_count: run rose after %0d ticks, expected 21", k);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
